// File: rtl/johnson_code_checker.sv
`default_nettype none
// ============================================================================
// Module : johnson_code_checker
// Decodes a sampled Johnson code bus and monitors sequence/lock with error count.
// Rev    : 1.0
// ============================================================================
module johnson_code_checker #(
    parameter int WIDTH      = 4,
    parameter int LOCK_CNT   = 3,
    parameter bit ALLOW_HOLD = 1'b1,
    parameter int ERR_W      = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [WIDTH-1:0]             code_in,
    input  logic                         code_valid,
    input  logic                         clr_err,
    output logic [$clog2(2*WIDTH)-1:0]   index_out,
    output logic                         index_valid,
    output logic                         illegal,
    output logic                         seq_err,
    output logic                         locked,
    output logic [ERR_W-1:0]             err_count
);

    localparam int               IDX_W   = $clog2(2*WIDTH);
    localparam int               SEQ_LEN = 2*WIDTH;
    localparam int               GOOD_W  = $clog2(LOCK_CNT+1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    last_idx_q, last_idx_d;
    logic [GOOD_W-1:0]   good_q, good_d;
    logic [IDX_W-1:0]    index_out_q, index_out_d;
    logic                index_valid_q, index_valid_d;
    logic                illegal_q, illegal_d;
    logic                seq_err_q, seq_err_d;
    logic                locked_q, locked_d;
    logic [ERR_W-1:0]    err_count_q, err_count_d;

    logic [IDX_W-1:0]    w_dec_idx;
    logic [WIDTH-1:0]    w_dec_pattern;
    logic                w_code_legal;
    logic [IDX_W-1:0]    w_expected;
    logic                w_is_next;
    logic                w_is_repeat;
    int                  w_ones;
    int                  w_k;

    // Decode from popcount, then rebuild the canonical code for that index;
    // the sample is legal only if it matches the rebuilt code exactly.
    always_comb begin
        w_ones = 0;
        for (int i = 0; i < WIDTH; i++) begin
            w_ones = w_ones + (code_in[i] ? 1 : 0);
        end
        w_k       = code_in[WIDTH-1] ? (SEQ_LEN - w_ones) : w_ones;
        w_dec_idx = IDX_W'(w_k);
        for (int i = 0; i < WIDTH; i++) begin
            w_dec_pattern[i] = (w_k <= WIDTH) ? (i < w_k) : (i >= w_k - WIDTH);
        end
        w_code_legal = (w_dec_pattern == code_in);
    end

    always_comb begin
        w_expected  = (last_idx_q == IDX_W'(SEQ_LEN-1)) ? '0 : last_idx_q + 1'b1;
        w_is_next   = (w_dec_idx == w_expected);
        w_is_repeat = (w_dec_idx == last_idx_q);
    end

    always_comb begin
        state_d       = state_q;
        last_idx_d    = last_idx_q;
        good_d        = good_q;
        index_out_d   = index_out_q;
        index_valid_d = 1'b0;
        illegal_d     = 1'b0;
        seq_err_d     = 1'b0;

        if (code_valid) begin
            if (!w_code_legal) begin
                illegal_d = 1'b1;
                state_d   = ST_HUNT;
                good_d    = '0;
            end else begin
                index_valid_d = 1'b1;
                index_out_d   = w_dec_idx;
                case (state_q)
                    ST_HUNT: begin
                        last_idx_d = w_dec_idx;
                        good_d     = '0;
                        state_d    = ST_CHECK;
                    end
                    ST_CHECK: begin
                        if (w_is_next) begin
                            good_d     = good_q + 1'b1;
                            last_idx_d = w_dec_idx;
                            if (good_d == GOOD_W'(LOCK_CNT)) begin
                                state_d = ST_LOCKED;
                            end
                        end else if (!(w_is_repeat && ALLOW_HOLD)) begin
                            last_idx_d = w_dec_idx;
                            good_d     = '0;
                        end
                    end
                    ST_LOCKED: begin
                        if (w_is_next || (w_is_repeat && ALLOW_HOLD)) begin
                            last_idx_d = w_dec_idx;
                        end else begin
                            seq_err_d  = 1'b1;
                            last_idx_d = w_dec_idx;
                            good_d     = '0;
                            state_d    = ST_CHECK;
                        end
                    end
                    default: begin
                        state_d = ST_HUNT;
                        good_d  = '0;
                    end
                endcase
            end
        end

        // Clear wins over a same-cycle error event; the pulse itself still fires.
        err_count_d = err_count_q;
        if (clr_err) begin
            err_count_d = '0;
        end else if ((illegal_d || seq_err_d) && (err_count_q != ERR_MAX)) begin
            err_count_d = err_count_q + 1'b1;
        end

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_HUNT;
            last_idx_q    <= '0;
            good_q        <= '0;
            index_out_q   <= '0;
            index_valid_q <= 1'b0;
            illegal_q     <= 1'b0;
            seq_err_q     <= 1'b0;
            locked_q      <= 1'b0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            last_idx_q    <= last_idx_d;
            good_q        <= good_d;
            index_out_q   <= index_out_d;
            index_valid_q <= index_valid_d;
            illegal_q     <= illegal_d;
            seq_err_q     <= seq_err_d;
            locked_q      <= locked_d;
            err_count_q   <= err_count_d;
        end
    end

    assign index_out   = index_out_q;
    assign index_valid = index_valid_q;
    assign illegal     = illegal_q;
    assign seq_err     = seq_err_q;
    assign locked      = locked_q;
    assign err_count   = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_johnson_code_checker.sv
`default_nettype none
// ============================================================================
// Module : tb_johnson_code_checker
// Directed and randomized checks of two checker instances against a sequence model.
// Rev    : 1.0
// ============================================================================
module tb_johnson_code_checker;

    logic       clk;
    logic       rst_n;
    logic [3:0] code_in;
    logic       code_valid;
    logic       clr_err;

    logic [2:0] a_idx, b_idx;
    logic       a_iv, a_ill, a_se, a_lk;
    logic       b_iv, b_ill, b_se, b_lk;
    logic [7:0] a_err;
    logic [1:0] b_err;

    int checks = 0;
    int errors = 0;

    johnson_code_checker #(.WIDTH(4), .LOCK_CNT(3), .ALLOW_HOLD(1'b1), .ERR_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .code_in(code_in), .code_valid(code_valid),
        .clr_err(clr_err), .index_out(a_idx), .index_valid(a_iv), .illegal(a_ill),
        .seq_err(a_se), .locked(a_lk), .err_count(a_err)
    );

    johnson_code_checker #(.WIDTH(4), .LOCK_CNT(3), .ALLOW_HOLD(1'b0), .ERR_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .code_in(code_in), .code_valid(code_valid),
        .clr_err(clr_err), .index_out(b_idx), .index_valid(b_iv), .illegal(b_ill),
        .seq_err(b_se), .locked(b_lk), .err_count(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        bit hunting;
        bit lock;
        int run;
        int last;
        int idx;
        bit iv;
        bit ill;
        bit se;
        int err;
    } mdl_t;

    mdl_t ma, mb;

    // Walk the Johnson sequence: shift left, feeding the inverted MSB into bit 0.
    function automatic logic [3:0] jcode(input int k);
        logic [3:0] p;
        p = 4'b0000;
        for (int i = 0; i < k; i++) p = {p[2:0], ~p[3]};
        return p;
    endfunction

    function automatic int jlookup(input logic [3:0] c);
        for (int k = 0; k < 8; k++) begin
            if (jcode(k) === c) return k;
        end
        return -1;
    endfunction

    function automatic mdl_t mreset();
        mdl_t s;
        s = '0;
        s.hunting = 1'b1;
        return s;
    endfunction

    function automatic mdl_t mstep(input mdl_t s, input bit v, input logic [3:0] c,
                                   input bit clr, input bit hold, input int emax);
        mdl_t n;
        int   k;
        bit   inseq, rep;
        n = s;
        n.iv = 1'b0; n.ill = 1'b0; n.se = 1'b0;
        if (v) begin
            k = jlookup(c);
            if (k < 0) begin
                n.ill = 1'b1; n.hunting = 1'b1; n.lock = 1'b0;
            end else begin
                n.iv  = 1'b1;
                n.idx = k;
                inseq = (k == (s.last + 1) % 8);
                rep   = (k == s.last) && hold;
                if (s.hunting) begin
                    n.hunting = 1'b0; n.run = 0; n.last = k;
                end else if (s.lock) begin
                    if (inseq || rep) n.last = k;
                    else begin n.se = 1'b1; n.lock = 1'b0; n.run = 0; n.last = k; end
                end else if (inseq) begin
                    n.run = s.run + 1; n.last = k;
                    if (n.run == 3) n.lock = 1'b1;
                end else if (!rep) begin
                    n.run = 0; n.last = k;
                end
            end
        end
        if (clr) n.err = 0;
        else if ((n.ill || n.se) && n.err < emax) n.err = n.err + 1;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma <= mreset();
            mb <= mreset();
        end else begin
            ma <= mstep(ma, code_valid, code_in, clr_err, 1'b1, 255);
            mb <= mstep(mb, code_valid, code_in, clr_err, 1'b0, 3);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("a.index_out", int'(a_idx), ma.idx);
            chk("a.index_valid", int'(a_iv), int'(ma.iv));
            chk("a.illegal", int'(a_ill), int'(ma.ill));
            chk("a.seq_err", int'(a_se), int'(ma.se));
            chk("a.locked", int'(a_lk), int'(ma.lock));
            chk("a.err_count", int'(a_err), ma.err);
            chk("b.index_out", int'(b_idx), mb.idx);
            chk("b.index_valid", int'(b_iv), int'(mb.iv));
            chk("b.illegal", int'(b_ill), int'(mb.ill));
            chk("b.seq_err", int'(b_se), int'(mb.se));
            chk("b.locked", int'(b_lk), int'(mb.lock));
            chk("b.err_count", int'(b_err), mb.err);
        end
    end

    task automatic cyc(input bit v, input logic [3:0] c, input bit clr);
        code_valid = v;
        code_in    = c;
        clr_err    = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".a_idx"}, int'(a_idx), 0);
        chk({tag, ".a_flags"}, int'({a_iv, a_ill, a_se, a_lk}), 0);
        chk({tag, ".a_err"}, int'(a_err), 0);
        chk({tag, ".b_idx"}, int'(b_idx), 0);
        chk({tag, ".b_flags"}, int'({b_iv, b_ill, b_se, b_lk}), 0);
        chk({tag, ".b_err"}, int'(b_err), 0);
    endtask

    initial begin
        int pos;
        int r;
        logic [3:0] c;

        rst_n = 1'b0; code_in = 4'b0; code_valid = 1'b0; clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Acquire lock on 0,1,2,3
        cyc(1, 4'b0000, 0); chk("t1.idx0", int'(a_idx), 0); chk("t1.iv0", int'(a_iv), 1);
        cyc(1, 4'b0001, 0); chk("t1.idx1", int'(a_idx), 1);
        cyc(1, 4'b0011, 0); chk("t1.idx2", int'(a_idx), 2); chk("t1.unlocked", int'(a_lk), 0);
        cyc(1, 4'b0111, 0); chk("t1.idx3", int'(a_idx), 3); chk("t1.locked", int'(a_lk), 1);
        chk("t1.err", int'(a_err), 0);
        chk("model.t1.lock", int'(ma.lock), 1);

        // Run across the wrap
        cyc(1, 4'b1111, 0);
        cyc(1, 4'b1110, 0);
        cyc(1, 4'b1100, 0); chk("t2.idx6", int'(a_idx), 6);
        cyc(1, 4'b1000, 0); chk("t2.idx7", int'(a_idx), 7);
        cyc(1, 4'b0000, 0); chk("t2.idx0", int'(a_idx), 0); chk("t2.locked", int'(a_lk), 1);
        chk("t2.seq_err", int'(a_se), 0);

        // Repeat: tolerated by a, sequence error on b
        cyc(1, 4'b0000, 0);
        chk("t5.a_locked", int'(a_lk), 1); chk("t5.a_se", int'(a_se), 0);
        chk("t5.b_se", int'(b_se), 1); chk("t5.b_locked", int'(b_lk), 0);
        chk("t5.b_err", int'(b_err), 1);

        // Illegal while locked
        cyc(1, 4'b0101, 0);
        chk("t3.ill", int'(a_ill), 1); chk("t3.iv", int'(a_iv), 0);
        chk("t3.idx_hold", int'(a_idx), 0); chk("t3.err", int'(a_err), 1);
        chk("t3.locked", int'(a_lk), 0);
        cyc(0, 4'b0000, 0); chk("t3.ill_pulse", int'(a_ill), 0);

        // Lock at idx2, then jump to idx4
        cyc(1, 4'b1000, 0); cyc(1, 4'b0000, 0); cyc(1, 4'b0001, 0); cyc(1, 4'b0011, 0);
        chk("t4.locked", int'(a_lk), 1);
        cyc(1, 4'b1111, 0);
        chk("t4.se", int'(a_se), 1); chk("t4.idx", int'(a_idx), 4); chk("t4.iv", int'(a_iv), 1);
        chk("t4.err", int'(a_err), 2); chk("t4.unlocked", int'(a_lk), 0);
        cyc(1, 4'b1110, 0); cyc(1, 4'b1100, 0); chk("t4.notyet", int'(a_lk), 0);
        cyc(1, 4'b1000, 0); chk("t4.relock", int'(a_lk), 1);
        chk("model.t4.err", ma.err, 2);

        // Saturation on the 2-bit counter, then clear racing an error
        cyc(0, 4'b0000, 1); chk("t6.clr", int'(b_err), 0);
        cyc(1, 4'b0101, 0); chk("t6.e1", int'(b_err), 1);
        cyc(1, 4'b1010, 0); chk("t6.e2", int'(b_err), 2);
        cyc(1, 4'b0110, 0); chk("t6.e3", int'(b_err), 3);
        cyc(1, 4'b1001, 0); chk("t6.sat", int'(b_err), 3); chk("t6.a_e4", int'(a_err), 4);
        cyc(1, 4'b1011, 1); chk("t6.clr_err", int'(b_err), 0); chk("t6.clr_ill", int'(b_ill), 1);
        chk("t6.a_clr", int'(a_err), 0);

        // Randomized traffic
        pos = 0;
        for (int n = 0; n < 1500; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 60) begin
                pos = (pos + 1) % 8; c = jcode(pos);
            end else if (r < 70) begin
                c = jcode(pos);
            end else if (r < 80) begin
                pos = int'($urandom_range(0, 7)); c = jcode(pos);
            end else begin
                c = 4'($urandom_range(0, 15));
            end
            cyc($urandom_range(0, 9) != 0, c, $urandom_range(0, 49) == 0);
        end

        // Asynchronous reset in the middle of a cycle
        cyc(1, 4'b0101, 0);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(1, 4'b0011, 0);
        chk("rst.reanchor_idx", int'(a_idx), 2); chk("rst.reanchor_lk", int'(a_lk), 0);
        cyc(1, 4'b0111, 0); cyc(1, 4'b1111, 0); cyc(1, 4'b1110, 0);
        chk("rst.relock", int'(a_lk), 1);
        cyc(0, 4'b0000, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
